edge_latency_sched: RTL and testbench

//  Shares one cycle counter among N_CH edge-latency channels. Requesters post a kick per

---
 rtl/edge_latency_sched_if.sv | 19 +
 rtl/edge_latency_sched.sv | 71 +++++++
 tb/tb_edge_latency_sched.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/edge_latency_sched_if.sv
// edge_latency_sched_if: kick/probe inputs and result outputs of the edge-latency scheduler
interface edge_latency_sched_if #(
  parameter int N_CH = 2,
  parameter int CNT_W = 16
);
  localparam int CH_W = $clog2(N_CH);
  logic en;
  logic abort;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] sig_i;
  logic [N_CH-1:0] pend_o;
  logic busy;
  logic res_vld;
  logic [CH_W-1:0] res_ch;
  logic [CNT_W-1:0] res_cnt;
  logic res_tmo;
  modport master(output en, abort, req, sig_i, input pend_o, busy, res_vld, res_ch, res_cnt, res_tmo);
  modport slave(input en, abort, req, sig_i, output pend_o, busy, res_vld, res_ch, res_cnt, res_tmo);
endinterface

// File: rtl/edge_latency_sched.sv
// edge_latency_sched: round-robin sharing of one cycle counter among edge-latency channels
module edge_latency_sched #(
  parameter int N_CH = 2,
  parameter int CNT_W = 16,
  parameter int TMO_CYC = 1000
) (
  input logic clk,
  input logic rst,
  edge_latency_sched_if.slave bus
);
  localparam int CH_W = $clog2(N_CH);
  typedef enum logic [1:0] {IDLE, ARM, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [N_CH-1:0] s1, s2, s3, rise, pend, clr;
  logic [CH_W-1:0] last, pick, idx, res_ch;
  logic [CNT_W-1:0] cnt, res_cnt;
  logic res_tmo, grant, hit, finish;
  // last doubles as the channel under measurement: it is only updated on a grant
  assign rise = s2 & ~s3;
  assign hit = rise[last];
  assign grant = state == IDLE && bus.en && |pend && !bus.abort;
  assign finish = state == WAIT && !bus.abort && (hit || cnt == CNT_W'(TMO_CYC - 1));
  assign clr = grant ? N_CH'(1) << pick : '0;
  always_comb begin
    pick = last;
    idx = '0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = CH_W'((int'(last) + i) % N_CH);
      pick = pend[idx] ? idx : pick;
    end
  end
  always_comb begin
    state_n = state;
    if (bus.abort) state_n = IDLE;
    else if (state == IDLE) state_n = grant ? ARM : IDLE;
    else if (state == ARM) state_n = WAIT;
    else if (state == WAIT) state_n = finish ? DONE : WAIT;
    else state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      pend <= '0;
      last <= CH_W'(N_CH - 1);
      cnt <= '0;
      res_ch <= '0;
      res_cnt <= '0;
      res_tmo <= 1'b0;
    end else begin
      state <= state_n;
      {s3, s2, s1} <= {s2, s1, bus.sig_i};
      pend <= bus.abort ? '0 : (pend & ~clr) | bus.req;
      if (grant) last <= pick;
      cnt <= state == ARM ? '0 : state == WAIT ? cnt + 1'b1 : cnt;
      if (finish) begin
        res_ch <= last;
        res_cnt <= hit ? cnt : CNT_W'(TMO_CYC);
        res_tmo <= !hit;
      end
    end
  end
  assign bus.pend_o = pend;
  assign bus.busy = state != IDLE;
  assign bus.res_vld = state == DONE && !bus.abort;
  assign bus.res_ch = res_ch;
  assign bus.res_cnt = res_cnt;
  assign bus.res_tmo = res_tmo;
endmodule

// File: tb/tb_edge_latency_sched.sv
// tb_edge_latency_sched: timestamp-based reference model with a result scoreboard
module tb_edge_latency_sched;
  localparam int N_CH = 2, CNT_W = 8, TMO = 16, MAXC = 4000;
  localparam int CH_W = $clog2(N_CH);
  typedef struct packed {logic [CH_W-1:0] ch; logic [CNT_W-1:0] cnt; logic tmo;} res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  edge_latency_sched_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus();
  edge_latency_sched #(.N_CH(N_CH), .CNT_W(CNT_W), .TMO_CYC(TMO)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  res_t q[$];
  logic [N_CH-1:0] hist [MAXC];
  logic [N_CH-1:0] mp, exp_pend, sv, rv;
  logic active, resolved, exp_busy, exp_vld, live;
  int t, arm_t, m_last, m_sel, checks, errors;
  res_t m_res, exp_res;
  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req_v, t);
    end
  endtask
  // hist[x] is the probe value the DUT samples at the end of cycle x
  function automatic logic rise(input int tt, input int ch);
    return hist[tt - 2][ch] & ~hist[tt - 3][ch];
  endfunction
  task automatic step(input logic e, input logic a, input logic [N_CH-1:0] r, input logic [N_CH-1:0] s);
    logic [N_CH-1:0] clr;
    @(negedge clk);
    rst = 1'b0;
    live = 1'b1;
    bus.en = e;
    bus.abort = a;
    bus.req = r;
    bus.sig_i = s;
    hist[t] = s;
    exp_busy = active;
    exp_pend = mp;
    exp_res = m_res;
    exp_vld = 1'b0;
    clr = '0;
    if (!active) begin
      if (!a && e && |mp) begin
        for (int i = 1; i <= N_CH; i++)
          if (mp[(m_last + i) % N_CH]) begin
            m_sel = (m_last + i) % N_CH;
            break;
          end
        m_last = m_sel;
        clr[m_sel] = 1'b1;
        active = 1'b1;
        arm_t = t + 1;
        resolved = 1'b0;
      end
    end else if (t > arm_t && !resolved) begin
      if (!a && rise(t, m_sel)) begin
        m_res = '{ch: CH_W'(m_sel), cnt: CNT_W'(t - arm_t - 1), tmo: 1'b0};
        resolved = 1'b1;
      end else if (!a && t - arm_t - 1 == TMO - 1) begin
        m_res = '{ch: CH_W'(m_sel), cnt: CNT_W'(TMO), tmo: 1'b1};
        resolved = 1'b1;
      end
    end else if (resolved) begin
      exp_vld = !a;
      if (!a) q.push_back(m_res);
      active = 1'b0;
    end
    if (a) active = 1'b0;
    mp = a ? '0 : (mp & ~clr) | r;
    t++;
  endtask
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bus.en = 1'b0;
    bus.abort = 1'b0;
    bus.req = '0;
    bus.sig_i = '0;
    mp = '0;
    active = 1'b0;
    resolved = 1'b0;
    m_last = N_CH - 1;
    m_res = '0;
    q.delete();
    #1;
    check(bus.busy == 1'b0 && bus.res_vld == 1'b0 && bus.pend_o == '0, "rst_ctl", {bus.busy, bus.res_vld, bus.pend_o}, 0);
    check({bus.res_ch, bus.res_cnt, bus.res_tmo} == '0, "rst_res", {bus.res_ch, bus.res_cnt, bus.res_tmo}, 0);
    hist[t] = '0;
    t++;
    @(negedge clk);
    hist[t] = '0;
    t++;
  endtask
  task automatic quiesce();
    step(1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (live && !rst) begin
        check(bus.busy === exp_busy, "busy", bus.busy, exp_busy);
        check(bus.pend_o === exp_pend, "pend", bus.pend_o, exp_pend);
        check(bus.res_vld === exp_vld, "res_vld", bus.res_vld, exp_vld);
        check({bus.res_ch, bus.res_cnt, bus.res_tmo} === exp_res, "res_regs", {bus.res_ch, bus.res_cnt, bus.res_tmo}, exp_res);
        if (bus.res_vld) begin
          if (q.size() == 0) check(1'b0, "res_unexpected", {bus.res_ch, bus.res_cnt, bus.res_tmo}, 0);
          else begin
            res_t e;
            e = q.pop_front();
            check({bus.res_ch, bus.res_cnt, bus.res_tmo} === e, "res", {bus.res_ch, bus.res_cnt, bus.res_tmo}, e);
          end
        end
      end
    end
  end
  initial begin
    for (int i = 0; i < MAXC; i++) hist[i] = '0;
    t = 0;
    checks = 0;
    errors = 0;
    live = 1'b0;
    m_sel = 0;
    arm_t = 0;
    reset_dut();
    // reset mid-WAIT on ch1 with both kicks pending, then both kicked again
    step(1'b1, 1'b0, 2'b10, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, i == 2 ? 2'b11 : 2'b00, '0);
    step(1'b1, 1'b0, '0, '0);
    reset_dut();
    step(1'b1, 1'b0, 2'b11, '0);
    for (int i = 0; i < 45; i++) step(1'b1, 1'b0, '0, '0);
    // single kick on ch1, probe first sampled high at WAIT edge 5
    quiesce();
    step(1'b1, 1'b0, 2'b10, '0);
    for (int i = 1; i < 14; i++) step(1'b1, 1'b0, '0, i >= 7 ? 2'b10 : 2'b00);
    // timeout, then a rise on the last WAIT cycle
    quiesce();
    step(1'b1, 1'b0, 2'b01, '0);
    for (int i = 1; i < 25; i++) step(1'b1, 1'b0, '0, '0);
    quiesce();
    step(1'b1, 1'b0, 2'b01, '0);
    for (int i = 1; i < 25; i++) step(1'b1, 1'b0, '0, i >= 16 ? 2'b01 : 2'b00);
    // fairness with both kicks held
    quiesce();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 2'b11, ((i / 3) % 2) != 0 ? 2'b11 : 2'b00);
    // abort in WAIT with ch0 re-kicked
    quiesce();
    step(1'b1, 1'b0, 2'b01, '0);
    for (int i = 1; i < 6; i++) step(1'b1, 1'b0, i == 4 ? 2'b01 : 2'b00, '0);
    step(1'b1, 1'b1, '0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, '0);
    // enable gating, then a probe already high at ARM
    quiesce();
    step(1'b0, 1'b0, 2'b01, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, i >= 4 ? 2'b01 : 2'b00);
    quiesce();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 2'b01);
    step(1'b1, 1'b0, 2'b01, 2'b01);
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0, '0, 2'b01);
    // randomized traffic with an occasional reset
    quiesce();
    sv = '0;
    for (int n = 0; n < 1500; n++) begin
      if (n == 750) reset_dut();
      for (int c = 0; c < N_CH; c++) if ($urandom_range(7) == 0) sv[c] = ~sv[c];
      rv = ($urandom_range(3) == 0) ? N_CH'($urandom) : '0;
      step($urandom_range(7) != 0, $urandom_range(99) == 0, rv, sv);
    end
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, '0, '0);
    #2;
    check(q.size() == 0, "res_missing", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
